sel_sweep_driver: RTL

Sequential stimulus stage sitting directly upstream of the 2-to-4 `Decoder`. On a start request it drives the decoder's `x`/`y` select inputs through the codes 00, 01, 10, 11, holding each code for a programmable number of cycles. It also takes the decoder's four outputs back and checks them against the expected one-hot value on the last cycle of every hold window. It replaces hand-timed testbench stimulus with a self-checking hardware sweep usable on-board.

---
 rtl/sel_sweep_pkg.sv | 27 ++
 rtl/sel_sweep_driver_dwell_counter.sv | 40 ++++
 rtl/sel_sweep_driver.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sel_sweep_pkg.sv
// Shared types and the code-to-one-hot mapping used by the sweep driver.
// The decoder it drives maps {x,y} to a one-hot {d,c,b,a}.
package sel_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    typedef logic [1:0] code_t;

    localparam code_t CODE_FIRST = 2'b00;
    localparam code_t CODE_LAST  = 2'b11;

    function automatic logic [3:0] expected_onehot(input code_t code);
        logic [3:0] onehot;
        case (code)
            2'b00:   onehot = 4'b0001;
            2'b01:   onehot = 4'b0010;
            2'b10:   onehot = 4'b0100;
            default: onehot = 4'b1000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/sel_sweep_driver_dwell_counter.sv
// Down-counter timing one hold window; a load of 0 is stored as 1 so a
// window always lasts at least one cycle and the count never underflows.
module dwell_counter #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] load_val_i,
    input  logic               en_i,
    output logic [DWELL_W-1:0] count_o,
    output logic               last_o
);

    localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

    logic [DWELL_W-1:0] count_q;
    logic [DWELL_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = (load_val_i == '0) ? ONE : load_val_i;
        end else if (en_i && (count_q > ONE)) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == ONE);

endmodule

// File: rtl/sel_sweep_driver.sv
// Sweeps the decoder select lines through 00..11 with a programmable hold,
// checking the returned one-hot on the last cycle of each hold window.
module sel_sweep_driver
    import sel_sweep_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mode,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [3:0]         dec_in,
    output logic               x,
    output logic               y,
    output logic               sel_valid,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code
);

    state_e             state_q, state_d;
    code_t              code_q, code_d;
    logic               mode_q, mode_d;
    logic               stop_q, stop_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               err_q, err_d;
    code_t              err_code_q, err_code_d;

    logic               x_q, x_d;
    logic               y_q, y_d;
    logic               sel_valid_q, sel_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               cnt_load;
    logic [DWELL_W-1:0] cnt_load_val;
    logic               cnt_en;
    logic [DWELL_W-1:0] cnt_count;
    logic               cnt_last;
    logic               check_cycle;

    dwell_counter #(
        .DWELL_W (DWELL_W)
    ) u_dwell_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .en_i       (cnt_en),
        .count_o    (cnt_count),
        .last_o     (cnt_last)
    );

    assign check_cycle = cnt_last && (cnt_count != '0);

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        mode_d       = mode_q;
        stop_d       = stop_q;
        dwell_d      = dwell_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        cnt_load     = 1'b0;
        cnt_load_val = dwell_q;
        cnt_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d       = mode;
                    dwell_d      = dwell;
                    stop_d       = 1'b0;
                    err_d        = 1'b0;
                    err_code_d   = CODE_FIRST;
                    code_d       = CODE_FIRST;
                    cnt_load     = 1'b1;
                    cnt_load_val = dwell;
                    state_d      = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                cnt_en = 1'b1;
                if (stop) begin
                    stop_d = 1'b1;
                end
                if (check_cycle) begin
                    if (dec_in != expected_onehot(code_q)) begin
                        err_d = 1'b1;
                        if (!err_q) begin
                            err_code_d = code_q;
                        end
                    end
                    // A stop arriving on the final check cycle still ends the run here.
                    if (code_q != CODE_LAST) begin
                        code_d   = code_q + 2'd1;
                        cnt_load = 1'b1;
                    end else if (!mode_q || stop_q || stop) begin
                        state_d = ST_FINISH;
                    end else begin
                        code_d   = CODE_FIRST;
                        cnt_load = 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of the next-state decode.
        x_d         = (state_d == ST_DRIVE) && code_d[1];
        y_d         = (state_d == ST_DRIVE) && code_d[0];
        sel_valid_d = (state_d == ST_DRIVE);
        busy_d      = (state_d == ST_DRIVE);
        done_d      = (state_d == ST_FINISH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            code_q      <= CODE_FIRST;
            mode_q      <= 1'b0;
            stop_q      <= 1'b0;
            dwell_q     <= '0;
            err_q       <= 1'b0;
            err_code_q  <= CODE_FIRST;
            x_q         <= 1'b0;
            y_q         <= 1'b0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            mode_q      <= mode_d;
            stop_q      <= stop_d;
            dwell_q     <= dwell_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sel_valid_q <= sel_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign sel_valid = sel_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule
